// File: rtl/stream_pkg.sv
// Shared constants, state encoding, output word layout and record sizing
// for the stream packer and its shift/merge datapath.
package stream_pkg;

    localparam int HDR_BITS       = 16;
    localparam int MAX_LEN        = 32;
    localparam int LEN_WIDTH      = 8;
    localparam int DATA_IN_WIDTH  = HDR_BITS + 8 * MAX_LEN;
    localparam int DATA_OUT_WIDTH = 256;
    // Worst case content: 255 bits left over plus one maximal 272-bit record.
    localparam int BUF_WIDTH      = 528;
    localparam int OCC_WIDTH      = 10;
    localparam int OUT_BITS_WIDTH = 9;

    // RUN accepts records; DRAIN flushes the tail of a finished stream.
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // Contents of the single output slot.
    typedef struct packed {
        logic                      last;
        logic [OUT_BITS_WIDTH-1:0] bits;
        logic [DATA_OUT_WIDTH-1:0] data;
    } out_word_t;

    // Record size in bits: oversize lengths saturate before scaling.
    function automatic logic [OCC_WIDTH-1:0] rec_bits(
        input logic [LEN_WIDTH-1:0] len,
        input int                   max_len,
        input int                   hdr_bits
    );
        int sat;
        sat = (int'(len) > max_len) ? max_len : int'(len);
        return OCC_WIDTH'(hdr_bits + 8 * sat);
    endfunction

endpackage

// File: rtl/stream_shift_merge.sv
// Combinational record insert: drop bits beyond the record length, move the
// record up to the current fill point, and OR it into the shift buffer.
module stream_shift_merge #(
    parameter int DIN_W = 272,
    parameter int BUF_W = 528,
    parameter int OCC_W = 10
) (
    input  logic [BUF_W-1:0] buf_in,
    input  logic [OCC_W-1:0] occ,
    input  logic [DIN_W-1:0] data,
    input  logic [OCC_W-1:0] nbits,
    output logic [BUF_W-1:0] buf_out
);

    logic [DIN_W-1:0] masked;
    logic [BUF_W-1:0] ext;

    // Per-bit keep mask; bits at or above the record length are don't-care upstream.
    genvar i;
    generate
        for (i = 0; i < DIN_W; i++) begin : g_mask
            assign masked[i] = data[i] & (i < int'(nbits));
        end
    endgenerate

    assign ext = BUF_W'(masked);

    // Buffer is zero above occ, so an OR is a safe append.
    always_comb begin
        buf_out = buf_in | (ext << occ);
    end

endmodule

// File: rtl/stream_packer.sv
// Packs variable-length header+payload records back-to-back into 256-bit
// words. Records append at the occupancy point of a wide shift buffer; full
// words leave from the bottom. End of stream flushes a zero-padded tail word.
module stream_packer #(
    parameter int DATA_IN_WIDTH  = stream_pkg::DATA_IN_WIDTH,
    parameter int LEN_WIDTH      = stream_pkg::LEN_WIDTH,
    parameter int DATA_OUT_WIDTH = stream_pkg::DATA_OUT_WIDTH,
    parameter int HDR_BITS       = stream_pkg::HDR_BITS,
    parameter int MAX_LEN        = stream_pkg::MAX_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_IN_WIDTH-1:0]  in_data,
    input  logic [LEN_WIDTH-1:0]      in_len,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_OUT_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic [8:0]                out_bits,
    output logic                      err_len
);
    import stream_pkg::*;

    logic [BUF_WIDTH-1:0] buffer;
    logic [BUF_WIDTH-1:0] merged;
    logic [OCC_WIDTH-1:0] occ;
    logic [OCC_WIDTH-1:0] rbits;
    logic [0:0]           state;
    out_word_t            out_q;

    logic occ_full;
    logic slot_free;
    logic accept;
    logic emit_full;
    logic emit_tail;
    logic last_taken;

    assign rbits      = rec_bits(in_len, MAX_LEN, HDR_BITS);
    assign occ_full   = (occ >= OCC_WIDTH'(DATA_OUT_WIDTH));
    assign slot_free  = !out_valid || out_ready;

    // Accept needs occ < 256 and a full emit needs occ >= 256, so they never
    // collide; a tail emit only happens in DRAIN, where nothing is accepted.
    assign in_ready   = (state == ST_RUN) && !occ_full;
    assign accept     = in_valid && in_ready;
    assign emit_full  = occ_full && slot_free;
    assign emit_tail  = (state == ST_DRAIN) && !occ_full && (occ != '0) && slot_free;
    assign last_taken = out_valid && out_ready && out_q.last;

    assign out_data = out_q.data;
    assign out_bits = out_q.bits;
    assign out_last = out_q.last;

    stream_shift_merge #(
        .DIN_W (DATA_IN_WIDTH),
        .BUF_W (BUF_WIDTH),
        .OCC_W (OCC_WIDTH)
    ) u_merge (
        .buf_in  (buffer),
        .occ     (occ),
        .data    (in_data),
        .nbits   (rbits),
        .buf_out (merged)
    );

    // Shift buffer and fill count: append on accept, drop a word on emit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer <= '0;
            occ    <= '0;
        end else if (accept) begin
            buffer <= merged;
            occ    <= occ + rbits;
        end else if (emit_full) begin
            buffer <= buffer >> DATA_OUT_WIDTH;
            occ    <= occ - OCC_WIDTH'(DATA_OUT_WIDTH);
        end else if (emit_tail) begin
            buffer <= '0;
            occ    <= '0;
        end
    end

    // Output slot: load a full or tail word when free, hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (emit_full) begin
            out_valid  <= 1'b1;
            out_q.data <= buffer[DATA_OUT_WIDTH-1:0];
            out_q.bits <= OUT_BITS_WIDTH'(DATA_OUT_WIDTH);
            // A stream ending exactly on a word boundary tags its last full word.
            out_q.last <= (state == ST_DRAIN) && (occ == OCC_WIDTH'(DATA_OUT_WIDTH));
        end else if (emit_tail) begin
            out_valid  <= 1'b1;
            out_q.data <= buffer[DATA_OUT_WIDTH-1:0];
            out_q.bits <= occ[OUT_BITS_WIDTH-1:0];
            out_q.last <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Stream state: enter DRAIN on the last record, back to RUN once the
    // final word has been handed over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else if (accept && in_last) begin
            state <= ST_DRAIN;
        end else if ((state == ST_DRAIN) && (occ == '0) && last_taken) begin
            state <= ST_RUN;
        end
    end

    // Sticky oversize-length flag, raised only for records actually taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_len <= 1'b0;
        end else if (accept && (int'(in_len) > MAX_LEN)) begin
            err_len <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer: a bit-queue reference model scores every word
// handed over, with table vectors, hand-written corner sequences and random
// streams under random backpressure.
module tb_stream_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [271:0] in_data = '0;
    logic [7:0]   in_len = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_data;
    logic         out_last;
    logic [8:0]   out_bits;
    logic         err_len;

    stream_packer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_bits  (out_bits),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    typedef struct { logic [271:0] data; logic [7:0] len; logic last; } rec_t;
    typedef struct { logic [255:0] data; int bits; logic last; } word_t;
    typedef struct { logic [7:0] len; int nwords; int lastbits; logic err; } vec_t;

    rec_t  src[$];
    word_t expq[$];
    bit    mq[$];
    int    total = 0;
    int    bad = 0;
    int    words_seen = 0;
    int    last_bits_seen = 0;
    bit    err_model = 0;
    int    vpct = 100;
    logic  s_in_ready;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input string got, input string exp);
        total++;
        bad++;
        $display("FAIL %s: got %s expected %s", name, got, exp);
    endtask

    function automatic logic [271:0] rand_data();
        logic [271:0] d;
        d = '0;
        for (int i = 0; i < 9; i++) d = {d[239:0], 32'($urandom())};
        return d;
    endfunction

    function automatic rec_t mk_rec(input int len, input logic last);
        rec_t r;
        r.data = rand_data();
        r.len  = 8'(len);
        r.last = last;
        return r;
    endfunction

    // Reference: the stream is one long bit sequence cut into 256-bit words.
    task automatic model_accept(input rec_t r);
        word_t w;
        int    l;
        int    n;
        l = (int'(r.len) > 32) ? 32 : int'(r.len);
        n = 16 + 8 * l;
        if (int'(r.len) > 32) err_model = 1;
        for (int i = 0; i < n; i++) mq.push_back(r.data[i]);
        while (mq.size() >= 256) begin
            w.data = '0;
            for (int i = 0; i < 256; i++) w.data[i] = mq.pop_front();
            w.bits = 256;
            w.last = 1'b0;
            expq.push_back(w);
        end
        if (r.last) begin
            if (mq.size() > 0) begin
                w.data = '0;
                w.bits = mq.size();
                for (int i = 0; i < w.bits; i++) w.data[i] = mq.pop_front();
                w.last = 1'b1;
                expq.push_back(w);
            end else begin
                w = expq.pop_back();
                w.last = 1'b1;
                expq.push_back(w);
            end
        end
    endtask

    // One clock: drive at the falling edge, observe handshakes just after.
    task automatic cycle(input int rpct);
        word_t w;
        @(negedge clk);
        if (src.size() > 0 && int'($urandom_range(99)) < vpct) begin
            in_valid = 1'b1;
            in_data  = src[0].data;
            in_len   = src[0].len;
            in_last  = src[0].last;
        end else begin
            in_valid = 1'b0;
            in_data  = rand_data();
            in_len   = 8'($urandom());
            in_last  = 1'($urandom());
        end
        out_ready = (int'($urandom_range(99)) < rpct);
        #1;
        s_in_ready = in_ready;
        if (in_valid && in_ready) model_accept(src.pop_front());
        if (out_valid && out_ready) begin
            words_seen++;
            if (out_last) last_bits_seen = int'(out_bits);
            if (expq.size() == 0) begin
                fail("extra_word", "unexpected word", "no word");
            end else begin
                w = expq.pop_front();
                chkd("word_data", out_data, w.data);
                chk("word_bits", longint'(out_bits), longint'(w.bits));
                chk("word_last", longint'(out_last), longint'(w.last));
            end
        end
    endtask

    task automatic run_idle(input int rpct, input string name);
        int n;
        n = 0;
        while ((src.size() > 0 || expq.size() > 0) && n < 3000) begin
            cycle(rpct);
            n++;
        end
        if (src.size() > 0 || expq.size() > 0) fail(name, "timeout", "stream drained");
    endtask

    // Asynchronous reset between edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chkd("rst_out_data", out_data, '0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_out_bits", longint'(out_bits), 0);
        chk("rst_err_len", longint'(err_len), 0);
        src.delete();
        expq.delete();
        mq.delete();
        err_model = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t         tbl[7];
        rec_t         r;
        logic [255:0] hold;
        int           n;
        int           cnt;

        // {len, words, bits of final word, err_len}
        tbl[0] = '{8'd0,   1, 16,  1'b0};
        tbl[1] = '{8'd3,   1, 40,  1'b0};
        tbl[2] = '{8'd30,  1, 256, 1'b0};
        tbl[3] = '{8'd31,  2, 8,   1'b0};
        tbl[4] = '{8'd32,  2, 16,  1'b0};
        tbl[5] = '{8'd40,  2, 16,  1'b1};
        tbl[6] = '{8'd255, 2, 16,  1'b1};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            vpct = 100;
            words_seen = 0;
            last_bits_seen = 0;
            src.push_back(mk_rec(int'(tbl[i].len), 1'b1));
            run_idle(100, "tbl_drain");
            cycle(100);
            chk("tbl_words", words_seen, tbl[i].nwords);
            chk("tbl_lastbits", last_bits_seen, tbl[i].lastbits);
            chk("tbl_err", longint'(err_len), longint'(tbl[i].err));
            chk("tbl_back_to_run", longint'(s_in_ready), 1);
        end

        // Latency: accepted at edge t, word visible after edge t+1.
        do_reset();
        r = mk_rec(30, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = r.data; in_len = r.len; in_last = 1'b0; out_ready = 1'b1;
        #1;
        chk("lat_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("lat_t0_valid", longint'(out_valid), 0);
        @(negedge clk);
        #1;
        chk("lat_t1_valid", longint'(out_valid), 1);
        chkd("lat_data", out_data, r.data[255:0]);
        chk("lat_bits", longint'(out_bits), 256);
        chk("lat_last", longint'(out_last), 0);
        @(negedge clk);
        #1;
        chk("lat_t2_valid", longint'(out_valid), 0);
        chk("lat_t2_ready", longint'(in_ready), 1);

        // Two 136-bit records: one word, 16 bits left over.
        do_reset();
        words_seen = 0;
        src.push_back(mk_rec(15, 1'b0));
        src.push_back(mk_rec(15, 1'b0));
        run_idle(100, "two_rec");
        chk("two_rec_words", words_seen, 1);
        src.push_back(mk_rec(0, 1'b1));
        run_idle(100, "two_rec_end");
        cycle(100);
        chk("two_rec_tail_bits", last_bits_seen, 32);

        // Spill: fill to 248, then a 272-bit record completes two words.
        do_reset();
        src.push_back(mk_rec(15, 1'b0));
        src.push_back(mk_rec(12, 1'b0));
        run_idle(100, "spill_fill");
        words_seen = 0;
        src.push_back(mk_rec(32, 1'b0));
        n = 0;
        while (src.size() > 0 && n < 20) begin cycle(100); n++; end
        if (src.size() > 0) fail("spill_accept", "timeout", "accepted");
        cycle(100);
        chk("spill_ready_a", longint'(s_in_ready), 0);
        cycle(100);
        chk("spill_ready_b", longint'(s_in_ready), 0);
        cycle(100);
        chk("spill_ready_c", longint'(s_in_ready), 1);
        chk("spill_words", words_seen, 2);
        src.push_back(mk_rec(0, 1'b1));
        run_idle(100, "spill_end");
        cycle(100);
        chk("spill_tail_bits", last_bits_seen, 24);

        // Backpressure: word held stable, intake stops once occ reaches 256.
        do_reset();
        src.push_back(mk_rec(30, 1'b0));
        src.push_back(mk_rec(32, 1'b0));
        src.push_back(mk_rec(32, 1'b0));
        n = 0;
        while (!out_valid && n < 20) begin cycle(0); n++; end
        if (!out_valid) fail("stall_first", "no word", "word pending");
        hold = out_data;
        for (int k = 0; k < 5; k++) begin
            cycle(0);
            chk("stall_valid", longint'(out_valid), 1);
            chkd("stall_data", out_data, hold);
        end
        chk("stall_in_ready", longint'(s_in_ready), 0);
        run_idle(100, "stall_release");
        src.push_back(mk_rec(0, 1'b1));
        run_idle(100, "stall_end");
        cycle(100);
        chk("stall_tail_bits", last_bits_seen, 48);

        // Oversize length is sticky; reset mid-stream clears everything.
        do_reset();
        src.push_back(mk_rec(40, 1'b0));
        src.push_back(mk_rec(20, 1'b0));
        src.push_back(mk_rec(20, 1'b0));
        cycle(0);
        cycle(0);
        chk("err_set", longint'(err_len), 1);
        for (int k = 0; k < 4; k++) cycle(100);
        chk("err_sticky", longint'(err_len), 1);
        do_reset();
        src.push_back(mk_rec(5, 1'b0));
        src.push_back(mk_rec(5, 1'b1));
        run_idle(100, "post_reset");
        cycle(100);
        chk("post_reset_tail_bits", last_bits_seen, 112);
        chk("post_reset_err", longint'(err_len), 0);

        // Random streams, random gaps and backpressure.
        for (int s = 0; s < 8; s++) begin
            int rp;
            do_reset();
            vpct = int'($urandom_range(50, 100));
            rp   = int'($urandom_range(30, 100));
            cnt  = int'($urandom_range(5, 25));
            for (int k = 0; k < cnt; k++) begin
                n = ($urandom_range(9) == 0) ? int'($urandom_range(33, 255)) : int'($urandom_range(0, 32));
                src.push_back(mk_rec(n, k == cnt - 1));
            end
            run_idle(rp, "rand_drain");
            vpct = 100;
            cycle(100);
            chk("rand_err", longint'(err_len), longint'(err_model));
            chk("rand_back_to_run", longint'(s_in_ready), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
